// File: rtl/dm_lsu_pkg.sv
// Shared types for the DM load/store controller: size encodings, FSM states,
// and the alignment/legality check applied at request accept.
package dm_lsu_pkg;

    localparam int unsigned DM_AW = 8;
    localparam int unsigned DW    = 32;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_R = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE,
        LD_WAIT,
        RMW_MERGE,
        RESP
    } state_t;

    // Misaligned half/word or reserved size: completes with an error and no DM access.
    function automatic logic is_bad_req(size_t size, logic [1:0] addr_lo);
        case (size)
            SZ_H:    return addr_lo[0];
            SZ_W:    return addr_lo != 2'b00;
            SZ_R:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dm_lsu_ctrl_if.sv
// Request/response bus between the MEM stage (master) and the LSU controller (slave).
//   req_*  : request fields, qualified by req_valid & req_ready
//   resp_* : completion pulse, load data and error flag
interface dm_lsu_ctrl_if;
    import dm_lsu_pkg::*;

    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    size_t         req_size;
    logic          req_signed;
    logic [DW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dm_lane_unit.sv
// Combinational lane logic for a 32-bit little-endian word.
//   word      : word read from DM
//   addr_lo   : byte offset within the word
//   size      : access size
//   sign_ext  : sign-extend sub-word loads
//   wdata     : right-justified store data
//   load_data : extracted and extended load result
//   merged    : word with the addressed lane(s) replaced by store data
module dm_lane_unit
    import dm_lsu_pkg::*;
(
    input  logic [DW-1:0] word,
    input  logic [1:0]    addr_lo,
    input  size_t         size,
    input  logic          sign_ext,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] load_data,
    output logic [DW-1:0] merged
);

    logic [4:0]  byte_sh;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sh  = {addr_lo, 3'b000};
    assign byte_sel = word[byte_sh +: 8];
    assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    // Load extract and extend
    always_comb begin
        load_data = word;
        case (size)
            SZ_B:    load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SZ_H:    load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: load_data = word;
        endcase
    end

    // Store merge into the read word
    always_comb begin
        merged = word;
        case (size)
            SZ_B: merged[byte_sh +: 8] = wdata[7:0];
            SZ_H: begin
                if (addr_lo[1]) merged[31:16] = wdata[15:0];
                else            merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/dm_lsu_ctrl.sv
// Load/store controller in front of a word-only, synchronous-read data memory.
//   clock, rst : clock and synchronous active-high reset
//   bus        : request/response interface (slave side)
//   dm_*       : DM address, write data, read/write enables, read data
// Sub-word stores are done as read-modify-write; one request outstanding at a time.
module dm_lsu_ctrl
    import dm_lsu_pkg::*;
(
    input  logic             clock,
    input  logic             rst,
    dm_lsu_ctrl_if.slave     bus,
    output logic [DM_AW-1:0] dm_address,
    output logic [DW-1:0]    dm_data,
    output logic             dm_rden,
    output logic             dm_wren,
    input  logic [DW-1:0]    dm_q
);

    state_t              state;
    state_t              state_nx;
    size_t               lat_size;
    logic                lat_signed;
    logic [DM_AW+1:0]    lat_addr;
    logic [DW-1:0]       lat_wdata;
    logic                accept_c;
    logic                bad_c;
    logic [DW-1:0]       load_data;
    logic [DW-1:0]       merged;
    logic                unused_addr_bits;

    // Address bits above the DM range wrap
    assign unused_addr_bits = ^bus.req_addr[DW-1:DM_AW+2];

    assign bus.req_ready  = (state == IDLE) && !rst;
    assign bus.resp_valid = (state == RESP);
    assign accept_c       = bus.req_valid && bus.req_ready;
    assign bad_c          = is_bad_req(bus.req_size, bus.req_addr[1:0]);

    dm_lane_unit u_lane (
        .word      (dm_q),
        .addr_lo   (lat_addr[1:0]),
        .size      (lat_size),
        .sign_ext  (lat_signed),
        .wdata     (lat_wdata),
        .load_data (load_data),
        .merged    (merged)
    );

    // State register
    always_ff @(posedge clock) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state and DM drive: live request fields in IDLE, latched fields afterwards
    always_comb begin
        state_nx   = state;
        dm_address = lat_addr[DM_AW+1:2];
        dm_data    = lat_wdata;
        dm_rden    = 1'b0;
        dm_wren    = 1'b0;
        case (state)
            IDLE: begin
                dm_address = bus.req_addr[DM_AW+1:2];
                dm_data    = bus.req_wdata;
                if (accept_c) begin
                    if (bad_c) begin
                        state_nx = RESP;
                    end else if (bus.req_we && bus.req_size == SZ_W) begin
                        dm_wren  = 1'b1;
                        state_nx = RESP;
                    end else if (bus.req_we) begin
                        dm_rden  = 1'b1;
                        state_nx = RMW_MERGE;
                    end else begin
                        dm_rden  = 1'b1;
                        state_nx = LD_WAIT;
                    end
                end
            end
            LD_WAIT: state_nx = RESP;
            RMW_MERGE: begin
                dm_data  = merged;
                dm_wren  = 1'b1;
                state_nx = RESP;
            end
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // A pending write or read is dropped in the reset cycle
        if (rst) begin
            dm_rden = 1'b0;
            dm_wren = 1'b0;
        end
    end

    // Request latch and response registers; rdata/err change only as resp_valid rises
    always_ff @(posedge clock) begin
        if (rst) begin
            lat_size       <= SZ_B;
            lat_signed     <= 1'b0;
            lat_addr       <= '0;
            lat_wdata      <= '0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
        end else begin
            if (accept_c) begin
                lat_size   <= bus.req_size;
                lat_signed <= bus.req_signed;
                lat_addr   <= bus.req_addr[DM_AW+1:0];
                lat_wdata  <= bus.req_wdata;
                if (bad_c) begin
                    bus.resp_rdata <= '0;
                    bus.resp_err   <= 1'b1;
                end else if (bus.req_we && bus.req_size == SZ_W) begin
                    bus.resp_rdata <= '0;
                    bus.resp_err   <= 1'b0;
                end
            end
            if (state == LD_WAIT) begin
                bus.resp_rdata <= load_data;
                bus.resp_err   <= 1'b0;
            end
            if (state == RMW_MERGE) begin
                bus.resp_rdata <= '0;
                bus.resp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dm_lsu_ctrl.sv
module tb_dm_lsu_ctrl;
    import dm_lsu_pkg::*;

    logic        clk;
    logic        rst;
    logic [7:0]  dm_address;
    logic [31:0] dm_data;
    logic        dm_rden;
    logic        dm_wren;
    logic [31:0] dm_q;

    dm_lsu_ctrl_if bus ();

    dm_lsu_ctrl dut (
        .clock      (clk),
        .rst        (rst),
        .bus        (bus),
        .dm_address (dm_address),
        .dm_data    (dm_data),
        .dm_rden    (dm_rden),
        .dm_wren    (dm_wren),
        .dm_q       (dm_q)
    );

    int checks = 0;
    int errors = 0;

    // DM model and access counters
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    int rd_cnt = 0;
    int wr_cnt = 0;
    int both_cnt = 0;

    always @(posedge clk) begin
        if (dm_wren) mem[dm_address] <= dm_data;
        if (dm_rden) dm_q <= mem[dm_address];
        if (dm_rden) rd_cnt <= rd_cnt + 1;
        if (dm_wren) wr_cnt <= wr_cnt + 1;
        if (dm_rden && dm_wren) both_cnt <= both_cnt + 1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observations of the last transaction
    logic [31:0] g_rdata;
    logic        g_err;
    int          g_lat;
    int          d_rd, d_wr;
    logic        c0_rden, c0_wren, c1_wren;
    logic [7:0]  c0_addr;
    logic [31:0] c0_data, c1_data;
    // Expectations of the last transaction from the reference model
    logic [31:0] e_rdata;
    logic        e_err;
    int          e_lat, e_rd, e_wr;

    // Transaction-level reference: memory as an array of words, byte lanes by shifting
    task automatic ref_access(input bit we, input logic [1:0] sz, input bit sg,
                              input logic [31:0] a, input logic [31:0] wd);
        int nbytes, sh;
        logic [31:0] mask, v;
        int idx;
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
        sh     = int'(a % 4) * 8;
        idx    = int'((a / 4) % 256);
        e_err  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && (a % 4) != 0);
        if (e_err) begin
            e_rdata = 32'h0; e_lat = 1; e_rd = 0; e_wr = 0;
        end else if (we) begin
            ref_mem[idx] = (ref_mem[idx] & ~(mask << sh)) | ((wd & mask) << sh);
            e_rdata = 32'h0; e_wr = 1;
            e_lat = (nbytes == 4) ? 1 : 2;
            e_rd  = (nbytes == 4) ? 0 : 1;
        end else begin
            v = (ref_mem[idx] >> sh) & mask;
            if (sg && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
            e_rdata = v; e_lat = 2; e_rd = 1; e_wr = 0;
        end
    endtask

    // One request, driven on the falling edge; latency counted in cycles after accept
    task automatic do_req(input bit we, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] wd);
        int rd0, wr0, guard;
        @(negedge clk);
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 20) begin
            errors++;
            $display("FAIL req_ready_wait: got ready=%b expected 1 within 20 cycles", bus.req_ready);
        end
        rd0 = rd_cnt; wr0 = wr_cnt;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size_t'(sz);
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        #1;
        c0_rden = dm_rden; c0_wren = dm_wren; c0_addr = dm_address; c0_data = dm_data;
        ref_access(we, sz, sg, a, wd);
        @(negedge clk);
        bus.req_valid = 1'b0;
        c1_wren = dm_wren; c1_data = dm_data;
        g_lat = 1;
        while (!bus.resp_valid && g_lat < 8) begin
            @(negedge clk);
            g_lat++;
        end
        g_rdata = bus.resp_rdata;
        g_err   = bus.resp_err;
        d_rd    = rd_cnt - rd0;
        d_wr    = wr_cnt - wr0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = SZ_W;
        bus.req_signed = 1'b0; bus.req_addr = 32'h4; bus.req_wdata = 32'h1234_5678;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (dm_wren !== 1'b0 || dm_rden !== 1'b0) begin
            errors++;
            $display("FAIL reset_dm_en: got rden=%b wren=%b expected 0 0", dm_rden, dm_wren);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 ||
            bus.resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got ready=%b valid=%b err=%b rdata=%h expected 1 0 0 00000000",
                     bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata);
        end
    endtask

    task automatic test_word_store_load();
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
        checks++;
        if (c0_wren !== 1'b1 || c0_rden !== 1'b0 || c0_addr !== 8'd4 || c0_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL word_store_c0: got wren=%b rden=%b addr=%h data=%h expected 1 0 04 deadbeef",
                     c0_wren, c0_rden, c0_addr, c0_data);
        end
        checks++;
        if (g_lat !== 1 || g_err !== 1'b0) begin
            errors++;
            $display("FAIL word_store_resp: got lat=%0d err=%b expected 1 0", g_lat, g_err);
        end
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        checks++;
        if (g_rdata !== 32'hDEAD_BEEF || g_lat !== 2 || c0_rden !== 1'b1) begin
            errors++;
            $display("FAIL word_load: got rdata=%h lat=%0d rden=%b expected deadbeef 2 1",
                     g_rdata, g_lat, c0_rden);
        end
    endtask

    task automatic test_byte_store_rmw();
        do_req(1'b1, 2'd2, 1'b0, 32'h80, 32'h1122_3344);
        do_req(1'b1, 2'd0, 1'b0, 32'h81, 32'h0000_00AA);
        checks++;
        if (c0_rden !== 1'b1 || c0_wren !== 1'b0 || c1_wren !== 1'b1 || c1_data !== 32'h1122_AA44) begin
            errors++;
            $display("FAIL byte_rmw: got rden0=%b wren0=%b wren1=%b data1=%h expected 1 0 1 1122aa44",
                     c0_rden, c0_wren, c1_wren, c1_data);
        end
        checks++;
        if (g_lat !== 2 || mem[32] !== 32'h1122_AA44) begin
            errors++;
            $display("FAIL byte_rmw_done: got lat=%0d mem=%h expected 2 1122aa44", g_lat, mem[32]);
        end
    endtask

    task automatic test_extend();
        do_req(1'b1, 2'd2, 1'b0, 32'h0, 32'h0080_FF7F);
        do_req(1'b0, 2'd0, 1'b1, 32'h1, 32'h0);
        checks++;
        if (g_rdata !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL lb_signed: got %h expected ffffffff", g_rdata);
        end
        do_req(1'b0, 2'd0, 1'b0, 32'h1, 32'h0);
        checks++;
        if (g_rdata !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL lb_unsigned: got %h expected 000000ff", g_rdata);
        end
        do_req(1'b0, 2'd1, 1'b1, 32'h2, 32'h0);
        checks++;
        if (g_rdata !== 32'h0000_0080) begin
            errors++;
            $display("FAIL lh_signed: got %h expected 00000080", g_rdata);
        end
    endtask

    task automatic test_errors();
        do_req(1'b0, 2'd2, 1'b0, 32'h6, 32'h0);
        checks++;
        if (g_err !== 1'b1 || g_rdata !== 32'h0 || g_lat !== 1 || d_rd !== 0 || d_wr !== 0) begin
            errors++;
            $display("FAIL err_word_load: got err=%b rdata=%h lat=%0d rd=%0d wr=%0d expected 1 0 1 0 0",
                     g_err, g_rdata, g_lat, d_rd, d_wr);
        end
        do_req(1'b1, 2'd1, 1'b0, 32'h3, 32'hFFFF);
        checks++;
        if (g_err !== 1'b1 || g_rdata !== 32'h0 || g_lat !== 1 || d_rd !== 0 || d_wr !== 0) begin
            errors++;
            $display("FAIL err_half_store: got err=%b rdata=%h lat=%0d rd=%0d wr=%0d expected 1 0 1 0 0",
                     g_err, g_rdata, g_lat, d_rd, d_wr);
        end
        do_req(1'b0, 2'd3, 1'b0, 32'h8, 32'h0);
        checks++;
        if (g_err !== 1'b1 || g_lat !== 1 || d_rd !== 0) begin
            errors++;
            $display("FAIL err_reserved: got err=%b lat=%0d rd=%0d expected 1 1 0", g_err, g_lat, d_rd);
        end
    endtask

    task automatic test_reset_mid_rmw();
        do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFE_F00D);
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = SZ_B;
        bus.req_signed = 1'b0; bus.req_addr = 32'h21; bus.req_wdata = 32'h55;
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (dm_wren !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_wren: got %b expected 0", dm_wren);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0 ||
            bus.resp_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got ready=%b valid=%b rdata=%h err=%b expected 1 0 0 0",
                     bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (mem[8] !== 32'hCAFE_F00D || bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_mem: got mem=%h valid=%b expected cafef00d 0", mem[8], bus.resp_valid);
        end
    endtask

    task automatic test_random();
        bit we, sg;
        logic [1:0] sz;
        logic [31:0] a, wd;
        for (int n = 0; n < 120; n++) begin
            we = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) < 9) ? 2'($urandom_range(0, 2)) : 2'd3;
            a  = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 9) < 7) begin
                if (sz == 2'd0) a = a | 32'($urandom_range(0, 3));
                if (sz == 2'd1) a = a | (32'($urandom_range(0, 1)) << 1);
            end else begin
                a = a | 32'($urandom_range(0, 3));
            end
            wd = $urandom;
            do_req(we, sz, sg, a, wd);
            checks++;
            if (g_rdata !== e_rdata || g_err !== e_err || g_lat !== e_lat || d_rd !== e_rd || d_wr !== e_wr) begin
                errors++;
                $display("FAIL random[%0d] we=%b sz=%0d sg=%b a=%h: got rdata=%h err=%b lat=%0d rd=%0d wr=%0d expected %h %b %0d %0d %0d",
                         n, we, sz, sg, a, g_rdata, g_err, g_lat, d_rd, d_wr, e_rdata, e_err, e_lat, e_rd, e_wr);
            end
        end
    endtask

    typedef struct {
        bit          we;
        logic [1:0]  sz;
        bit          sg;
        logic [31:0] a;
        logic [31:0] wd;
    } req_t;

    task automatic test_back_to_back();
        req_t reqs [$];
        logic [31:0] exp_rdata [$];
        logic        exp_err [$];
        int i, cyc, nresp;
        bit outstanding;
        req_t r;
        reqs.push_back('{1'b1, 2'd2, 1'b0, 32'h400, 32'h5A5A_1234});
        reqs.push_back('{1'b0, 2'd2, 1'b0, 32'h000, 32'h0});
        reqs.push_back('{1'b1, 2'd0, 1'b0, 32'h003, 32'h99});
        reqs.push_back('{1'b0, 2'd1, 1'b1, 32'h002, 32'h0});
        reqs.push_back('{1'b0, 2'd2, 1'b0, 32'h001, 32'h0});
        reqs.push_back('{1'b0, 2'd0, 1'b0, 32'h403, 32'h0});
        reqs.push_back('{1'b1, 2'd1, 1'b0, 32'h402, 32'hBEEF});
        reqs.push_back('{1'b0, 2'd2, 1'b0, 32'h800, 32'h0});
        i = 0; cyc = 0; nresp = 0; outstanding = 1'b0;
        while ((i < reqs.size() || outstanding) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.resp_valid) begin
                nresp++;
                checks++;
                if (exp_rdata.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra_resp: got resp_valid=1 expected no response");
                end else if (bus.resp_rdata !== exp_rdata[0] || bus.resp_err !== exp_err[0] ||
                             bus.req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_resp[%0d]: got rdata=%h err=%b ready=%b expected %h %b 0",
                             nresp, bus.resp_rdata, bus.resp_err, bus.req_ready, exp_rdata[0], exp_err[0]);
                end
                if (exp_rdata.size() != 0) begin
                    void'(exp_rdata.pop_front());
                    void'(exp_err.pop_front());
                end
                outstanding = 1'b0;
            end else if (outstanding) begin
                checks++;
                if (bus.req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_ready_busy: got ready=%b expected 0", bus.req_ready);
                end
            end
            if (i < reqs.size()) begin
                r = reqs[i];
                bus.req_valid = 1'b1; bus.req_we = r.we; bus.req_size = size_t'(r.sz);
                bus.req_signed = r.sg; bus.req_addr = r.a; bus.req_wdata = r.wd;
                #1;
                if (bus.req_ready && !bus.resp_valid && !outstanding) begin
                    ref_access(r.we, r.sz, r.sg, r.a, r.wd);
                    exp_rdata.push_back(e_rdata);
                    exp_err.push_back(e_err);
                    outstanding = 1'b1;
                    i++;
                end
            end else begin
                bus.req_valid = 1'b0;
            end
        end
        bus.req_valid = 1'b0;
        checks++;
        if (nresp !== reqs.size() || cyc >= 200) begin
            errors++;
            $display("FAIL b2b_count: got %0d responses in %0d cycles expected %0d", nresp, cyc, reqs.size());
        end
    endtask

    task automatic test_final_state();
        int bad;
        @(negedge clk);
        bad = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== ref_mem[k]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mem_compare: got %0d differing words expected 0", bad);
        end
        checks++;
        if (both_cnt != 0) begin
            errors++;
            $display("FAIL rden_wren_overlap: got %0d cycles expected 0", both_cnt);
        end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin
            mem[k] = 32'h0;
            ref_mem[k] = 32'h0;
        end
        dm_q = 32'h0;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = SZ_B;
        bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        test_reset();
        test_word_store_load();
        test_byte_store_rmw();
        test_extend();
        test_errors();
        test_reset_mid_rmw();
        test_random();
        test_back_to_back();
        test_final_state();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
